// File: rtl/core_clk_seq.sv
// PLL-lock qualification, SDRAM wait and core reset sequencing; derives CPU and audio clock enables.
// core_reset/running are registered from next state; enables decode registered counters and are gated by pause.
module core_clk_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 256,
    parameter int CE_DIV             = 6,
    parameter int AUD_DIV            = 512
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pll_locked,
    input  logic sdram_ready,
    input  logic pause,
    output logic core_reset,
    output logic ce_cpu,
    output logic ce_cpu_n,
    output logic ce_aud,
    output logic running,
    output logic lock_lost
);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_STABLE    = 3'd1;
    localparam logic [2:0] S_WAIT_RAM  = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CE_DIV);
    localparam int AUD_W   = (AUD_DIV > 1) ? $clog2(AUD_DIV) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CE_DIV / 2 - 1);
    localparam logic [AUD_W-1:0] AUD_LAST  = AUD_W'(AUD_DIV - 1);

    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_reset_q, core_reset_d;
    logic             running_q, running_d;
    logic             lock_lost_q, lock_lost_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [AUD_W-1:0] acnt_q, acnt_d;
    logic             div_en;

    always_comb begin
        lock_meta_d = pll_locked;
        lock_s_d    = lock_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = lock_lost_q;
        case (state_q)
            S_WAIT_LOCK: if (lock_s_q) state_d = S_STABLE;
            S_STABLE: begin
                if (!lock_s_q)               state_d = S_WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = S_WAIT_RAM;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            S_WAIT_RAM: begin
                if (!lock_s_q) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (sdram_ready) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!lock_s_q) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end
            end
            default: state_d = S_WAIT_LOCK;
        endcase
        // The shared counter restarts from zero in every new state.
        if (state_d != state_q) cnt_d = '0;
        core_reset_d = (state_d != S_RUN);
        running_d    = (state_d == S_RUN);
    end

    // Dividers freeze (not clear) under pause so release resumes on the same phase.
    always_comb begin
        div_en = (state_q == S_RUN) && !pause;
        div_d  = div_q;
        acnt_d = acnt_q;
        if (state_q != S_RUN) begin
            div_d  = '0;
            acnt_d = '0;
        end else if (div_en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (div_q == DIV_LAST) acnt_d = (acnt_q == AUD_LAST) ? '0 : acnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= S_WAIT_LOCK;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            lock_lost_q  <= 1'b0;
            div_q        <= '0;
            acnt_q       <= '0;
        end else begin
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            lock_lost_q  <= lock_lost_d;
            div_q        <= div_d;
            acnt_q       <= acnt_d;
        end
    end

    assign ce_cpu     = div_en && (div_q == DIV_LAST);
    assign ce_cpu_n   = div_en && (div_q == DIV_HALF);
    assign ce_aud     = ce_cpu && (acnt_q == AUD_LAST);
    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign lock_lost  = lock_lost_q;

endmodule
